// File: rtl/iob_pack.sv
// Bit packer: concatenates width_i-bit items MSB-first into DATA_W-bit words through a
// 2*DATA_W-bit left-aligned buffer (valid bits at the top, zeros below).
module iob_pack #(
  parameter int DATA_W = 21
) (
  input  logic                    clk_i,
  input  logic                    cke_i,
  input  logic                    arst_n_i,
  input  logic                    rst_i,
  input  logic                    wrap_i,
  input  logic [$clog2(DATA_W):0] width_i,
  input  logic                    flush_i,
  output logic                    read_o,
  input  logic                    rready_i,
  input  logic [DATA_W-1:0]       rdata_i,
  output logic                    write_o,
  input  logic                    wready_i,
  output logic [DATA_W-1:0]       wdata_o
);

  localparam int AW = $clog2(DATA_W) + 1;
  localparam int BW = 2 * DATA_W;
  localparam int LW = $clog2(BW) + 1;

  localparam logic [AW-1:0] DW_A  = AW'(DATA_W);
  localparam logic [AW:0]   DW_A1 = (AW + 1)'(DATA_W);
  localparam logic [LW:0]   DW_L  = (LW + 1)'(DATA_W);
  localparam logic [LW:0]   BW_L  = (LW + 1)'(BW);

  typedef enum logic [1:0] {S_READ, S_PUSH, S_WRITE, S_FLUSH} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   sbuf_q, sbuf_d;
  logic [LW-1:0]   level_q, level_d;
  logic [AW-1:0]   wacc_q, wacc_d;
  logic            flush_q, flush_d;
  logic            rd, wr, live;

  logic [AW-1:0]     w_eff;
  logic [AW:0]       wsum;
  logic [LW:0]       lvl_x, w_x, lvl_plus_w, pad_x, shamt;
  logic [DATA_W-1:0] item_m, top_w;
  logic [BW-1:0]     item_sh;

  // All sums carry one spare bit so the fit checks cannot wrap around.
  assign w_eff      = (width_i > DW_A) ? DW_A : width_i;
  assign wsum       = {1'b0, wacc_q} + {1'b0, w_eff};
  assign lvl_x      = {1'b0, level_q};
  assign w_x        = (LW + 1)'(w_eff);
  assign lvl_plus_w = lvl_x + w_x;
  assign pad_x      = (LW + 1)'(DW_A - wacc_q);
  assign item_m     = rdata_i & ~({DATA_W{1'b1}} << w_eff);
  assign shamt      = BW_L - lvl_plus_w;
  assign item_sh    = {{DATA_W{1'b0}}, item_m} << shamt;
  assign top_w      = sbuf_q[BW-1 -: DATA_W];

  always_comb begin
    state_d = state_q;
    sbuf_d  = sbuf_q;
    level_d = level_q;
    wacc_d  = wacc_q;
    flush_d = flush_q | flush_i;
    rd      = 1'b0;
    wr      = 1'b0;
    case (state_q)
      S_READ: begin
        if (flush_d) begin
          state_d = S_FLUSH;
        end else if (wrap_i && (wsum > DW_A1)) begin
          level_d = LW'(lvl_x + pad_x);
          wacc_d  = '0;
          state_d = S_WRITE;
        end else if (rready_i && (w_eff != '0) && (lvl_plus_w <= BW_L)) begin
          rd      = 1'b1;
          state_d = S_PUSH;
        end else begin
          state_d = S_WRITE;
        end
      end
      S_PUSH: begin
        sbuf_d  = sbuf_q | item_sh;
        level_d = LW'(lvl_plus_w);
        wacc_d  = (wsum >= DW_A1) ? AW'(wsum - DW_A1) : AW'(wsum);
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if ((lvl_x >= DW_L) && wready_i) begin
          wr      = 1'b1;
          sbuf_d  = sbuf_q << DATA_W;
          level_d = LW'(lvl_x - DW_L);
        end
        state_d = S_READ;
      end
      S_FLUSH: begin
        // Whole words still buffered drain first; the zero tail below level pads the last one.
        if (level_q == '0) begin
          wacc_d  = '0;
          flush_d = 1'b0;
          state_d = S_READ;
        end else if (wready_i) begin
          wr = 1'b1;
          if (lvl_x >= DW_L) begin
            sbuf_d  = sbuf_q << DATA_W;
            level_d = LW'(lvl_x - DW_L);
          end else begin
            sbuf_d  = '0;
            level_d = '0;
            wacc_d  = '0;
            flush_d = 1'b0;
            state_d = S_READ;
          end
        end
      end
      default: state_d = S_READ;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= S_READ;
      sbuf_q  <= '0;
      level_q <= '0;
      wacc_q  <= '0;
      flush_q <= 1'b0;
    end else if (rst_i) begin
      state_q <= S_READ;
      sbuf_q  <= '0;
      level_q <= '0;
      wacc_q  <= '0;
      flush_q <= 1'b0;
    end else if (cke_i) begin
      state_q <= state_d;
      sbuf_q  <= sbuf_d;
      level_q <= level_d;
      wacc_q  <= wacc_d;
      flush_q <= flush_d;
    end
  end

  // Strobes must never fire while held in reset or with the clock disabled.
  assign live    = arst_n_i & ~rst_i & cke_i;
  assign read_o  = rd & live;
  assign write_o = wr & live;
  assign wdata_o = write_o ? top_w : '0;

endmodule

// File: tb/tb_iob_pack.sv
// Directed bench for iob_pack (DATA_W=8): queue-backed upstream FIFO, scoreboard of
// expected words checked by a monitor whenever write_o fires.
module tb_iob_pack;

  localparam int DW = 8;

  logic          clk_i = 1'b0;
  logic          cke_i = 1'b1;
  logic          arst_n_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          wrap_i = 1'b0;
  logic [3:0]    width_i = 4'd4;
  logic          flush_i = 1'b0;
  logic          read_o;
  logic          rready_i = 1'b0;
  logic [DW-1:0] rdata_i = '0;
  logic          write_o;
  logic          wready_i = 1'b1;
  logic [DW-1:0] wdata_o;

  logic [DW-1:0] expq[$];
  logic [DW-1:0] upq[$];
  logic [DW-1:0] exp_w;
  logic          rd_en = 1'b1;

  int mon_run = 0, mon_fail = 0, dir_run = 0, dir_fail = 0;
  int reads = 0, writes = 0;

  always #5 clk_i = ~clk_i;

  iob_pack #(.DATA_W(DW)) dut (
    .clk_i(clk_i), .cke_i(cke_i), .arst_n_i(arst_n_i), .rst_i(rst_i),
    .wrap_i(wrap_i), .width_i(width_i), .flush_i(flush_i),
    .read_o(read_o), .rready_i(rready_i), .rdata_i(rdata_i),
    .write_o(write_o), .wready_i(wready_i), .wdata_o(wdata_o)
  );

  // Upstream FIFO "not empty" flag, refreshed after the stimulus settles each cycle.
  always @(posedge clk_i) begin
    #2;
    rready_i = rd_en && (upq.size() != 0);
  end

  // Monitor: scoreboard check on every write, upstream pop on every read.
  always @(negedge clk_i) begin
    if (write_o) begin
      writes++;
      mon_run++;
      if (expq.size() == 0) begin
        mon_fail++;
        $display("[TB] FAIL word: got %02h, required no write", wdata_o);
      end else begin
        exp_w = expq.pop_front();
        if (wdata_o !== exp_w) begin
          mon_fail++;
          $display("[TB] FAIL word: got %02h, required %02h", wdata_o, exp_w);
        end else begin
          $display("[TB] word %02h ok", wdata_o);
        end
      end
    end
    if (read_o) begin
      reads++;
      if (upq.size() != 0) rdata_i = upq.pop_front();
      else rdata_i = '0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    dir_run++;
    if (got !== req) begin
      dir_fail++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, got, req);
    end else begin
      $display("[TB] %s = %0h ok", name, got);
    end
  endtask

  task automatic drain(input string name, input int budget);
    int c = 0;
    while ((expq.size() != 0 || upq.size() != 0) && c < budget) begin
      tick(1);
      c++;
    end
    chk({name, " pending"}, expq.size() + upq.size(), 0);
    tick(6);
  endtask

  task automatic pulse_flush();
    flush_i = 1'b1;
    tick(1);
    flush_i = 1'b0;
  endtask

  int w0, r0, c;

  initial begin
    // Reset: strobes and data held low even with the upstream FIFO offering data.
    upq.push_back(8'h77);
    tick(3);
    chk("reset read_o", read_o, 0);
    chk("reset write_o", write_o, 0);
    chk("reset wdata_o", wdata_o, 0);
    upq.delete();
    tick(2);
    arst_n_i = 1'b1;
    tick(2);

    // Two nibbles form one word; a flush afterwards finds nothing pending.
    width_i = 4'd4;
    upq.push_back(8'hA); upq.push_back(8'hB); expq.push_back(8'hAB);
    drain("w4", 100);
    w0 = writes;
    pulse_flush();
    tick(10);
    chk("w4 flush empty", writes - w0, 0);

    // Bits above width ignored, and oversize width clamps to a full word.
    upq.push_back(8'hF3); upq.push_back(8'h1C); expq.push_back(8'h3C);
    drain("mask", 100);
    width_i = 4'd15;
    upq.push_back(8'h5A); expq.push_back(8'h5A);
    drain("clamp", 100);

    // Width 3 without wrap, items straddle words; clock enable dropped midway.
    width_i = 4'd3;
    foreach (upq[i]) ;
    upq.push_back(8'd5); upq.push_back(8'd3); upq.push_back(8'd7); upq.push_back(8'd1);
    upq.push_back(8'd2); upq.push_back(8'd6); upq.push_back(8'd4); upq.push_back(8'd0);
    expq.push_back(8'hAF); expq.push_back(8'h95); expq.push_back(8'hA0);
    tick(4);
    cke_i = 1'b0;
    tick(6);
    cke_i = 1'b1;
    drain("w3", 200);

    // Wrap: 5,3 then zero pad; 7 opens the next word, emitted by flush.
    wrap_i = 1'b1;
    upq.push_back(8'd5); upq.push_back(8'd3); upq.push_back(8'd7);
    expq.push_back(8'hAC);
    drain("wrap", 100);
    expq.push_back(8'hE0);
    pulse_flush();
    drain("wrap flush", 50);
    wrap_i = 1'b0;

    // Flush of a partial word, then a second flush finds level 0.
    upq.push_back(8'd5); upq.push_back(8'd3);
    tick(20);
    expq.push_back(8'hAC);
    pulse_flush();
    drain("flush", 50);
    w0 = writes;
    pulse_flush();
    tick(10);
    chk("flush level0", writes - w0, 0);

    // Width 0 never reads.
    width_i = 4'd0;
    r0 = reads;
    upq.push_back(8'h55);
    tick(20);
    chk("w0 reads", reads - r0, 0);
    upq.delete();
    tick(2);

    // Backpressure: buffer fills after two bytes, then everything drains in order.
    width_i = 4'd8;
    wready_i = 1'b0;
    r0 = reads;
    w0 = writes;
    upq.push_back(8'h11); upq.push_back(8'h22); upq.push_back(8'h33); upq.push_back(8'h44);
    tick(40);
    chk("bp reads", reads - r0, 2);
    chk("bp writes", writes - w0, 0);
    expq.push_back(8'h11); expq.push_back(8'h22); expq.push_back(8'h33); expq.push_back(8'h44);
    wready_i = 1'b1;
    drain("bp", 100);

    // Async reset while in PUSH, then a fresh stream packs from the MSB.
    width_i = 4'd3;
    wready_i = 1'b0;
    upq.push_back(8'd5); upq.push_back(8'd3); upq.push_back(8'd7); upq.push_back(8'd1);
    c = 0;
    do begin
      @(negedge clk_i);
      c++;
    end while (!read_o && c < 50);
    chk("arst read seen", read_o, 1);
    @(posedge clk_i);
    #1;
    arst_n_i = 1'b0;
    #1;
    chk("arst read_o", read_o, 0);
    chk("arst write_o", write_o, 0);
    upq.delete();
    wready_i = 1'b1;
    tick(2);
    arst_n_i = 1'b1;
    width_i = 4'd4;
    upq.push_back(8'h3); upq.push_back(8'hC); expq.push_back(8'h3C);
    drain("post arst", 100);

    // Synchronous soft reset mid-stream with pending bits and a waiting item.
    width_i = 4'd3;
    wready_i = 1'b0;
    for (int i = 1; i <= 6; i++) upq.push_back(DW'(i));
    tick(30);
    rst_i = 1'b1;
    wready_i = 1'b1;
    tick(1);
    chk("rst read_o", read_o, 0);
    chk("rst write_o", write_o, 0);
    chk("rst wdata_o", wdata_o, 0);
    upq.delete();
    tick(2);
    rst_i = 1'b0;
    width_i = 4'd4;
    upq.push_back(8'h9); upq.push_back(8'h6); expq.push_back(8'h96);
    drain("post rst", 100);
    w0 = writes;
    pulse_flush();
    tick(10);
    chk("post rst level0", writes - w0, 0);

    $display("[TB] %0d tests run, %0d failed", dir_run + mon_run, dir_fail + mon_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
